// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct constants and
// the decode record handed from the decoder to the issue stage.
package alu_pkg;

  localparam logic [3:0] ALUOP_ADD     = 4'd0;
  localparam logic [3:0] ALUOP_SUB     = 4'd1;
  localparam logic [3:0] ALUOP_SLL     = 4'd2;
  localparam logic [3:0] ALUOP_AND     = 4'd3;
  localparam logic [3:0] ALUOP_SRL     = 4'd4;
  localparam logic [3:0] ALUOP_NOR     = 4'd5;
  localparam logic [3:0] ALUOP_SRA     = 4'd6;
  localparam logic [3:0] ALUOP_XOR     = 4'd7;
  localparam logic [3:0] ALUOP_REPL_QB = 4'd8;
  localparam logic [3:0] ALUOP_LUI     = 4'd9;
  localparam logic [3:0] ALUOP_OR      = 4'd10;
  localparam logic [3:0] ALUOP_SLT     = 4'd11;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL3 = 6'h1F;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_REPL_QB = 6'h12;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  // Source of operand B
  typedef enum logic [1:0] {
    B_RT   = 2'd0,
    B_SEXT = 2'd1,
    B_ZEXT = 2'd2
  } b_sel_e;

  // Source of the shift amount
  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_IMM  = 2'd1,
    SH_RS   = 2'd2
  } sh_sel_e;

  typedef struct packed {
    logic [3:0] alu_op;
    b_sel_e     b_sel;
    sh_sel_e    sh_sel;
    logic       repl;
    logic       ovfl_en;
    logic [4:0] dest;
    logic       writes;
    logic       illegal;
  } alu_decode_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction handshake plus the registered ALU
// controls presented to the execute stage.
interface alu_issue_stage_if #(
  parameter int WORD_SIZE = 32
);
  logic                   i_valid;
  logic                   o_ready;
  logic [31:0]            i_instr;
  logic [WORD_SIZE-1:0]   i_rs_data;
  logic [WORD_SIZE-1:0]   i_rt_data;
  logic                   i_flush;
  logic                   i_ex_ready;
  logic                   o_valid;
  logic [3:0]             o_ALUOP;
  logic [WORD_SIZE-1:0]   o_A;
  logic [WORD_SIZE-1:0]   o_B;
  logic [4:0]             o_Shamt;
  logic [WORD_SIZE/4-1:0] o_qByte;
  logic                   o_ovfl_en;
  logic [4:0]             o_rd_addr;
  logic                   o_reg_write;
  logic                   o_illegal;

  // Driver side: upstream register read plus the execute stage
  modport master (
    output i_valid, i_instr, i_rs_data, i_rt_data, i_flush, i_ex_ready,
    input  o_ready, o_valid, o_ALUOP, o_A, o_B, o_Shamt, o_qByte,
           o_ovfl_en, o_rd_addr, o_reg_write, o_illegal
  );

  // Issue stage side
  modport slave (
    input  i_valid, i_instr, i_rs_data, i_rt_data, i_flush, i_ex_ready,
    output o_ready, o_valid, o_ALUOP, o_A, o_B, o_Shamt, o_qByte,
           o_ovfl_en, o_rd_addr, o_reg_write, o_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decoder producing the ALU operation and the
// operand/shift selects; undecodable words collapse to a harmless add.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  output alu_decode_t o_dec
);

  // Map opcode/funct to operation, operand sources and destination
  always_comb begin
    o_dec         = '0;
    o_dec.b_sel   = B_RT;
    o_dec.sh_sel  = SH_NONE;
    o_dec.writes  = 1'b1;
    o_dec.dest    = i_rd;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  begin o_dec.alu_op = ALUOP_ADD; o_dec.ovfl_en = 1'b1; end
          FN_ADDU: o_dec.alu_op = ALUOP_ADD;
          FN_SUB:  begin o_dec.alu_op = ALUOP_SUB; o_dec.ovfl_en = 1'b1; end
          FN_SUBU: o_dec.alu_op = ALUOP_SUB;
          FN_AND:  o_dec.alu_op = ALUOP_AND;
          FN_OR:   o_dec.alu_op = ALUOP_OR;
          FN_XOR:  o_dec.alu_op = ALUOP_XOR;
          FN_NOR:  o_dec.alu_op = ALUOP_NOR;
          FN_SLT:  o_dec.alu_op = ALUOP_SLT;
          FN_SLL:  begin o_dec.alu_op = ALUOP_SLL; o_dec.sh_sel = SH_IMM; end
          FN_SRL:  begin o_dec.alu_op = ALUOP_SRL; o_dec.sh_sel = SH_IMM; end
          FN_SRA:  begin o_dec.alu_op = ALUOP_SRA; o_dec.sh_sel = SH_IMM; end
          FN_SLLV: begin o_dec.alu_op = ALUOP_SLL; o_dec.sh_sel = SH_RS; end
          FN_SRLV: begin o_dec.alu_op = ALUOP_SRL; o_dec.sh_sel = SH_RS; end
          FN_SRAV: begin o_dec.alu_op = ALUOP_SRA; o_dec.sh_sel = SH_RS; end
          default: o_dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_dec.alu_op = ALUOP_ADD; o_dec.ovfl_en = 1'b1;
        o_dec.b_sel = B_SEXT; o_dec.dest = i_rt;
      end
      OP_ADDIU: begin
        o_dec.alu_op = ALUOP_ADD; o_dec.b_sel = B_SEXT; o_dec.dest = i_rt;
      end
      OP_SLTI: begin
        o_dec.alu_op = ALUOP_SLT; o_dec.b_sel = B_SEXT; o_dec.dest = i_rt;
      end
      OP_ANDI: begin
        o_dec.alu_op = ALUOP_AND; o_dec.b_sel = B_ZEXT; o_dec.dest = i_rt;
      end
      OP_ORI: begin
        o_dec.alu_op = ALUOP_OR; o_dec.b_sel = B_ZEXT; o_dec.dest = i_rt;
      end
      OP_XORI: begin
        o_dec.alu_op = ALUOP_XOR; o_dec.b_sel = B_ZEXT; o_dec.dest = i_rt;
      end
      // The ALU performs the upper-half placement; B carries the raw immediate
      OP_LUI: begin
        o_dec.alu_op = ALUOP_LUI; o_dec.b_sel = B_ZEXT; o_dec.dest = i_rt;
      end
      OP_SPECIAL3: begin
        if (i_funct == FN_REPL_QB) begin
          o_dec.alu_op = ALUOP_REPL_QB;
          o_dec.repl   = 1'b1;
        end else begin
          o_dec.illegal = 1'b1;
        end
      end
      default: o_dec.illegal = 1'b1;
    endcase

    // Illegal words must not write back, trap or shift
    if (o_dec.illegal) begin
      o_dec.alu_op  = ALUOP_ADD;
      o_dec.b_sel   = B_RT;
      o_dec.sh_sel  = SH_NONE;
      o_dec.repl    = 1'b0;
      o_dec.ovfl_en = 1'b0;
      o_dec.dest    = 5'd0;
      o_dec.writes  = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes one instruction per handshake and
// holds the ALU controls/operands in the ID/EX register with stall and flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int IMM_SIZE  = 16
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  alu_issue_stage_if.slave bus
);

  localparam int QB_W = WORD_SIZE / 4;

  alu_decode_t dec;

  logic                 valid_q,     valid_d;
  logic [3:0]           alu_op_q,    alu_op_d;
  logic [WORD_SIZE-1:0] a_q,         a_d;
  logic [WORD_SIZE-1:0] b_q,         b_d;
  logic [4:0]           shamt_q,     shamt_d;
  logic [QB_W-1:0]      qbyte_q,     qbyte_d;
  logic                 ovfl_en_q,   ovfl_en_d;
  logic [4:0]           rd_addr_q,   rd_addr_d;
  logic                 reg_write_q, reg_write_d;
  logic                 illegal_q,   illegal_d;

  logic                 ready;
  logic                 accept;
  logic [IMM_SIZE-1:0]  imm;
  logic [WORD_SIZE-1:0] imm_sext;
  logic [WORD_SIZE-1:0] imm_zext;
  logic                 unused_rs_field;

  alu_op_decode u_decode (
    .i_opcode (bus.i_instr[31:26]),
    .i_funct  (bus.i_instr[5:0]),
    .i_rt     (bus.i_instr[20:16]),
    .i_rd     (bus.i_instr[15:11]),
    .o_dec    (dec)
  );

  // The rs register number is already resolved into i_rs_data upstream
  assign unused_rs_field = ^bus.i_instr[25:21];

  assign imm      = bus.i_instr[IMM_SIZE-1:0];
  assign imm_sext = {{(WORD_SIZE-IMM_SIZE){imm[IMM_SIZE-1]}}, imm};
  assign imm_zext = {{(WORD_SIZE-IMM_SIZE){1'b0}}, imm};

  assign ready  = ~valid_q | bus.i_ex_ready;
  assign accept = bus.i_valid & ready & ~bus.i_flush;

  // Next-state for the ID/EX register: load on accept, otherwise hold
  always_comb begin
    alu_op_d    = alu_op_q;
    a_d         = a_q;
    b_d         = b_q;
    shamt_d     = shamt_q;
    qbyte_d     = qbyte_q;
    ovfl_en_d   = ovfl_en_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    // Flush wins over both a new accept and a stalled hold
    valid_d     = accept | (valid_q & ~bus.i_ex_ready & ~bus.i_flush);

    if (accept) begin
      alu_op_d    = dec.alu_op;
      a_d         = bus.i_rs_data;
      case (dec.b_sel)
        B_SEXT:  b_d = imm_sext;
        B_ZEXT:  b_d = imm_zext;
        default: b_d = bus.i_rt_data;
      endcase
      case (dec.sh_sel)
        SH_IMM:  shamt_d = bus.i_instr[10:6];
        SH_RS:   shamt_d = bus.i_rs_data[4:0];
        default: shamt_d = 5'd0;
      endcase
      qbyte_d     = dec.repl ? bus.i_instr[16 +: QB_W] : '0;
      ovfl_en_d   = dec.ovfl_en;
      rd_addr_d   = dec.dest;
      // Writes to $zero are architecturally discarded, so never request them
      reg_write_d = dec.writes & (dec.dest != 5'd0);
      illegal_d   = dec.illegal;
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      valid_q     <= 1'b0;
      alu_op_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      shamt_q     <= '0;
      qbyte_q     <= '0;
      ovfl_en_q   <= 1'b0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      shamt_q     <= shamt_d;
      qbyte_q     <= qbyte_d;
      ovfl_en_q   <= ovfl_en_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_ALUOP     = alu_op_q;
  assign bus.o_A         = a_q;
  assign bus.o_B         = b_q;
  assign bus.o_Shamt     = shamt_q;
  assign bus.o_qByte     = qbyte_q;
  assign bus.o_ovfl_en   = ovfl_en_q;
  assign bus.o_rd_addr   = rd_addr_q;
  assign bus.o_reg_write = reg_write_q;
  assign bus.o_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver pushes the reference
// model's result for every accepted instruction, the monitor compares the
// held ID/EX contents every cycle and retires entries on drain or flush.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  alu_issue_stage_if #(.WORD_SIZE(32)) bus ();

  alu_issue_stage #(.WORD_SIZE(32), .IMM_SIZE(16)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [7:0]  qb;
    logic        ovfl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   m_valid = 1'b0;

  int rfn [15] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A,
                   'h00, 'h02, 'h03, 'h04, 'h06, 'h07};
  int iop [7]  = '{'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each instruction, written from the ISA table
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t e;
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    logic [31:0] imm_z = {16'h0000, ins[15:0]};
    logic [31:0] imm_s = {{16{ins[15]}}, ins[15:0]};
    e.a = rs; e.b = rt; e.shamt = 5'd0; e.qb = 8'd0; e.ovfl = 1'b0;
    e.alu = 4'd0; e.ill = 1'b0; e.rd = ins[15:11];
    if (op == 0) begin
      case (fn)
        'h20: begin e.alu = 4'd0; e.ovfl = 1'b1; end
        'h21: e.alu = 4'd0;
        'h22: begin e.alu = 4'd1; e.ovfl = 1'b1; end
        'h23: e.alu = 4'd1;
        'h24: e.alu = 4'd3;
        'h25: e.alu = 4'd10;
        'h26: e.alu = 4'd7;
        'h27: e.alu = 4'd5;
        'h2A: e.alu = 4'd11;
        'h00: begin e.alu = 4'd2; e.shamt = ins[10:6]; end
        'h02: begin e.alu = 4'd4; e.shamt = ins[10:6]; end
        'h03: begin e.alu = 4'd6; e.shamt = ins[10:6]; end
        'h04: begin e.alu = 4'd2; e.shamt = 5'(rs % 32); end
        'h06: begin e.alu = 4'd4; e.shamt = 5'(rs % 32); end
        'h07: begin e.alu = 4'd6; e.shamt = 5'(rs % 32); end
        default: e.ill = 1'b1;
      endcase
    end else if (op == 31 && fn == 'h12) begin
      e.alu = 4'd8;
      e.qb  = ins[23:16];
    end else begin
      e.rd = ins[20:16];
      case (op)
        'h08: begin e.alu = 4'd0;  e.ovfl = 1'b1; e.b = imm_s; end
        'h09: begin e.alu = 4'd0;  e.b = imm_s; end
        'h0A: begin e.alu = 4'd11; e.b = imm_s; end
        'h0C: begin e.alu = 4'd3;  e.b = imm_z; end
        'h0D: begin e.alu = 4'd10; e.b = imm_z; end
        'h0E: begin e.alu = 4'd7;  e.b = imm_z; end
        'h0F: begin e.alu = 4'd9;  e.b = imm_z; end
        default: e.ill = 1'b1;
      endcase
    end
    e.rw = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    int k = int'($urandom_range(0, 9));
    logic [31:0] base = $urandom;
    if (k <= 4)      return {6'h00, base[25:6], 6'(rfn[$urandom_range(0, 14)])};
    else if (k <= 7) return {6'(iop[$urandom_range(0, 6)]), base[25:0]};
    else if (k == 8) return {6'h1F, base[25:6], 6'h12};
    else             return base;
  endfunction

  // Present one cycle of stimulus; called just after a rising edge
  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input bit fl, input bit exr);
    bit acc;
    bus.i_valid    = v;
    bus.i_instr    = ins;
    bus.i_rs_data  = rs;
    bus.i_rt_data  = rt;
    bus.i_flush    = fl;
    bus.i_ex_ready = exr;
    acc = v && (!m_valid || exr) && !fl;
    @(posedge clk);
    if (acc) q.push_back(model(ins, rs, rt));
    m_valid = acc || (m_valid && !exr && !fl);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " o_valid"},     32'(bus.o_valid),     32'd0);
    chk({tag, " o_ready"},     32'(bus.o_ready),     32'd1);
    chk({tag, " o_ALUOP"},     32'(bus.o_ALUOP),     32'd0);
    chk({tag, " o_A"},         bus.o_A,              32'd0);
    chk({tag, " o_B"},         bus.o_B,              32'd0);
    chk({tag, " o_Shamt"},     32'(bus.o_Shamt),     32'd0);
    chk({tag, " o_qByte"},     32'(bus.o_qByte),     32'd0);
    chk({tag, " o_ovfl_en"},   32'(bus.o_ovfl_en),   32'd0);
    chk({tag, " o_rd_addr"},   32'(bus.o_rd_addr),   32'd0);
    chk({tag, " o_reg_write"}, 32'(bus.o_reg_write), 32'd0);
    chk({tag, " o_illegal"},   32'(bus.o_illegal),   32'd0);
  endtask

  // Monitor: mid-cycle comparison of the held instruction against the queue head
  initial begin
    exp_t e;
    bit   exp_valid;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_valid = (q.size() != 0);
        chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
        chk("o_ready", 32'(bus.o_ready), 32'(!exp_valid || bus.i_ex_ready));
        if (exp_valid && bus.o_valid) begin
          e = q[0];
          chk("o_ALUOP",     32'(bus.o_ALUOP),     32'(e.alu));
          chk("o_A",         bus.o_A,              e.a);
          chk("o_Shamt",     32'(bus.o_Shamt),     32'(e.shamt));
          chk("o_qByte",     32'(bus.o_qByte),     32'(e.qb));
          chk("o_ovfl_en",   32'(bus.o_ovfl_en),   32'(e.ovfl));
          chk("o_reg_write", 32'(bus.o_reg_write), 32'(e.rw));
          chk("o_illegal",   32'(bus.o_illegal),   32'(e.ill));
          if (!e.ill) begin
            chk("o_B",       bus.o_B,              e.b);
            chk("o_rd_addr", 32'(bus.o_rd_addr),   32'(e.rd));
          end
        end
        if (exp_valid && (bus.i_ex_ready || bus.i_flush)) void'(q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_instr    = '0;
    bus.i_rs_data  = '0;
    bus.i_rt_data  = '0;
    bus.i_flush    = 1'b0;
    bus.i_ex_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    mon_en = 1'b1;

    // add $3,$1,$2
    drive(1, 32'h00221820, 32'd5, 32'd7, 0, 1);
    // srav $4,$5,$6 with rs_data=0x23, then sra $4,$5,9
    drive(1, 32'h00C52007, 32'h23, 32'h1234, 0, 1);
    drive(1, 32'h00052243, 32'h23, 32'h8000_0000, 0, 1);
    // lui $8,0xABCD and slti $9,$1,-1
    drive(1, 32'h3C08ABCD, 32'h55, 32'h66, 0, 1);
    drive(1, 32'h2829FFFF, 32'h77, 32'h88, 0, 1);
    // NOP and repl.qb
    drive(1, 32'h00000000, 32'h9, 32'hA, 0, 1);
    drive(1, 32'h7C5A1892, 32'h1, 32'h2, 0, 1);
    // Stall for three cycles with a new instruction waiting, then release
    drive(1, 32'h00A62022, 32'h100, 32'h50, 0, 1);
    repeat (3) drive(1, 32'h35EFF00F, 32'h0F0F0F0F, 32'h3, 0, 0);
    drive(1, 32'h35EFF00F, 32'h0F0F0F0F, 32'h3, 0, 1);
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1);
    // Flush of an incoming instruction, then flush of a stalled one
    drive(1, 32'h00221820, 32'd1, 32'd2, 1, 1);
    drive(1, 32'h20A5FFFE, 32'd3, 32'd4, 0, 1);
    drive(1, 32'h00221820, 32'd1, 32'd2, 0, 0);
    drive(1, 32'h00221820, 32'd1, 32'd2, 1, 0);
    // Undecodable opcode 0x3F and an unknown R-type funct
    drive(1, 32'hFC4318A5, 32'h11, 32'h22, 0, 1);
    drive(1, 32'h0043183F, 32'h33, 32'h44, 0, 1);
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
    end
    repeat (2) drive(0, 32'h0, 32'h0, 32'h0, 0, 1);

    // Reset asserted while an instruction is stalled
    drive(1, 32'h00221820, 32'd5, 32'd7, 0, 1);
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("stall_reset");
    q.delete();
    m_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage that produces every control and operand input the pipeline ALU consumes. Accepts one MIPS instruction plus register-file read data per handshake, decodes opcode/funct into the 4-bit ALU operation code, selects and extends operands, and holds the result in the ID/EX register under a valid/ready handshake with stall and flush. It sits between register read and the ALU, and is the only writer of the ALU's operation, operand, shift-amount and byte-replicate inputs.

## Interface
- WORD_SIZE, 32, datapath width
- IMM_SIZE, 16, immediate field width
- i_CLK  in  1  clock, all state on rising edge
- i_RST_N  in  1  asynchronous, active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept this cycle
- i_instr  in  32  instruction word
- i_rs_data  in  WORD_SIZE  rs register value
- i_rt_data  in  WORD_SIZE  rt register value
- i_flush  in  1  discard held and incoming instruction
- i_ex_ready  in  1  ALU stage accepts o_* this cycle
- o_valid  out  1  registered outputs hold a live instruction
- o_ALUOP  out  4  ALU operation code
- o_A, o_B  out  WORD_SIZE  ALU operands
- o_Shamt  out  5  shift amount
- o_qByte  out  WORD_SIZE/4  byte to replicate
- o_ovfl_en  out  1  trap on ALU overflow
- o_rd_addr  out  5  destination register
- o_reg_write  out  1  write-back enable
- o_illegal  out  1  instruction not decodable

## Operation
- ALUOP codes: 0 add, 1 sub, 2 sll, 3 and, 4 srl, 5 nor, 6 sra, 7 xor, 8 repl.qb, 9 lui, 10 or, 11 slt; 12–15 never issued.
- R-type (opcode 0x00), B=rt, dest=rd: funct 0x20 add (ovfl_en=1), 0x21 addu→0, 0x22 sub (ovfl_en=1), 0x23 subu→1, 0x24→3, 0x25→10, 0x26→7, 0x27→5, 0x2A→11; 0x00/0x02/0x03 → 2/4/6 with Shamt=instr[10:6]; 0x04/0x06/0x07 → 2/4/6 with Shamt=rs_data[4:0].
- I-type, dest=rt: 0x08 addi→0 ovfl_en=1, 0x09 addiu→0, 0x0A slti→11 (B sign-extended); 0x0C andi→3, 0x0D ori→10, 0x0E xori→7 (B zero-extended); 0x0F lui→9, B zero-extended imm.
- Opcode 0x1F with funct 0x12 → 8, qByte=instr[23:16], dest=rd.
- o_A=rs_data always; Shamt=0 and qByte=0 for non-shift/non-repl ops.
- Anything else: o_illegal=1, ALUOP=0, reg_write=0, ovfl_en=0.
- o_reg_write = decoded write & (dest≠0); NOP word 0x00000000 issues with reg_write=0.

## Timing
- o_ready = ~o_valid | i_ex_ready (combinational).
- Accept when i_valid & o_ready & ~i_flush: all o_* load next edge, o_valid=1; latency one cycle.
- Stall (o_valid & ~i_ex_ready): all o_* held stable, upstream back-pressured.
- Drain (o_valid & i_ex_ready & no accept): o_valid←0, data registers hold.
- i_flush: o_valid←0 next edge, overrides simultaneous accept; data registers not loaded.
- Back-to-back: accept with i_ex_ready=1 every cycle sustains one instruction per cycle.
- Reset (any time, mid-stall included): all outputs 0 immediately; o_ready=1.

## Structure
- Package alu_pkg: ALUOP localparams, opcode and funct constants, shared by ALU and this stage.
- Sub-module alu_op_decode: purely combinational instr→{ALUOP, operand selects, ovfl_en, dest, illegal}; top holds handshake and ID/EX register.

## Test plan
- Reset asserted during stall with o_valid=1 → all outputs 0, o_ready=1 before next edge.
- add $3,$1,$2 (0x00221820), rs=5, rt=7 → next cycle o_ALUOP=0, A=5, B=7, ovfl_en=1, rd=3, reg_write=1.
- srav $4,$5,$6, rs_data=0x23 → ALUOP=6, Shamt=3; sra with instr[10:6]=9 → Shamt=9.
- lui $8,0xABCD → ALUOP=9, B=0x0000ABCD, rd=8; slti imm 0xFFFF → B=0xFFFFFFFF, ALUOP=11.
- i_ex_ready=0 for 3 cycles with new i_valid → o_* unchanged, o_ready=0; release → next instruction issues following cycle.
- i_flush with i_valid=1 → o_valid=0 next edge; opcode 0x3F → o_illegal=1, reg_write=0.
